bcd_serial_add_ctrl: RTL

BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

---
 rtl/bcd_serial_add_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one shared 4-bit decimal digit stage processes
// one digit per clock, least-significant first, with start/ready/busy/done handshake.
module bcd_serial_add_ctrl #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              cin,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] sum,
  output logic              cout,
  output logic              err
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t            state_reg, state_next;
  logic [4*NDIG-1:0] a_reg, b_reg;
  logic              cin_reg;
  logic [IW-1:0]     idx_reg;
  logic              carry_reg;
  logic              cout_reg;
  logic              err_reg;

  logic              accept;
  logic              step;
  logic              last;
  logic [3:0]        ad, bd, dig_val;
  logic              c_in, dig_carry;
  logic [4:0]        t;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ADD;
      ADD:     if (idx_reg == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign accept = (state_reg == IDLE) && start;
  assign step   = (state_reg == ADD);
  assign last   = (idx_reg == LAST_IDX);

  // Select the captured operand digits for the current index.
  always_comb begin
    ad = '0;
    bd = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_reg == IW'(i)) begin
        ad = a_reg[4*i +: 4];
        bd = b_reg[4*i +: 4];
      end
    end
  end

  // Digit 0 takes the captured carry-in; later digits take the registered carry.
  assign c_in = (idx_reg == '0) ? cin_reg : carry_reg;
  assign t    = {1'b0, ad} + {1'b0, bd} + {4'b0, c_in};

  always_comb begin
    dig_val   = t[3:0];
    dig_carry = 1'b0;
    if (t > 5'd9) begin
      dig_val   = t[3:0] + 4'd6;
      dig_carry = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      cin_reg   <= 1'b0;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      cin_reg   <= cin;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else if (step) begin
      carry_reg <= dig_carry;
      if ((ad > 4'd9) || (bd > 4'd9)) err_reg <= 1'b1;
      if (last) begin
        cout_reg <= dig_carry;
        idx_reg  <= '0;
      end else begin
        idx_reg  <= idx_reg + IW'(1);
      end
    end
  end

  // Each result digit is its own register, written only when the index selects it.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
      logic [3:0] dig_reg;
      always_ff @(posedge clk) begin
        if (rst || accept)                       dig_reg <= '0;
        else if (step && (idx_reg == IW'(gi)))   dig_reg <= dig_val;
      end
      assign sum[4*gi +: 4] = dig_reg;
    end
  endgenerate

  assign ready = (state_reg == IDLE);
  assign busy  = (state_reg == ADD);
  assign done  = (state_reg == DONE);
  assign cout  = cout_reg;
  assign err   = err_reg;

endmodule
